mips_pc_unit: RTL

- Program-counter and next-PC stage directly upstream of instruction fetch in mips_cpu_harvard; drives instr_address.
- Implements MIPS-I jump/branch semantics with a single branch delay slot (j/jal/jr/jalr/bxx). Decode supplies targets or offsets; this block sequences them.
- Provides the link value for jal/jalr. Owns the halt-on-jump-to-zero rule that drops active.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_branch_target.sv | 15 +
 rtl/mips_pc_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS program-counter stage.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] LINK_OFFSET          = 32'd8;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

endpackage

// File: rtl/mips_branch_target.sv
// Conditional-branch target: PC + 4 + (sign-extended word offset), wrapping mod 2^32.
module mips_branch_target
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] offset,
    output logic [31:0] target
);

    logic [31:0] offset_bytes;

    assign offset_bytes = {{14{offset[15]}}, offset, 2'b00};
    assign target       = pc + INSTR_BYTES + offset_bytes;

endmodule

// File: rtl/mips_pc_unit.sv
// Program counter with one branch delay slot and halt-on-jump-to-HALT_ADDR.
// Optional misaligned-target trap is compiled in with `define MIPS_PC_ALIGN_CHECK_EN.
module mips_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        branch_req,
    input  logic [15:0] branch_offset,
    output logic [31:0] instr_address,
    output logic [31:0] link_addr,
    output logic        in_delay_slot,
    output logic        active,
    output logic        addr_error
);

    // State moves only when adv is high: clk_enable=1 and stall=0, reset taking priority.
    logic        adv;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    pc_state_t   state_q, state_d;
    logic [31:0] branch_target;

    assign adv = clk_enable & ~stall & ~reset;

    mips_branch_target u_branch_target (
        .pc     (pc_q),
        .offset (branch_offset),
        .target (branch_target)
    );

`ifdef MIPS_PC_ALIGN_CHECK_EN
    logic addr_error_q, addr_error_d;
`endif

    always_comb begin
        pc_d      = pc_q;
        pending_d = pending_q;
        state_d   = state_q;
`ifdef MIPS_PC_ALIGN_CHECK_EN
        addr_error_d = addr_error_q;
`endif
        if (adv) begin
            case (state_q)
                RUN: begin
                    pc_d = pc_q + INSTR_BYTES;
                    if (jump_req) begin
                        pending_d = jump_target;
                        state_d   = DELAY;
                    end else if (branch_req) begin
                        pending_d = branch_target;
                        state_d   = DELAY;
                    end
                end
                DELAY: begin
`ifdef MIPS_PC_ALIGN_CHECK_EN
                    if (pending_q[1:0] != 2'b00) begin
                        addr_error_d = 1'b1;
                        pc_d         = HALT_ADDR;
                        state_d      = HALTED;
                    end else if (pending_q == HALT_ADDR) begin
                        pc_d    = HALT_ADDR;
                        state_d = HALTED;
                    end else begin
                        pc_d    = pending_q;
                        state_d = RUN;
                    end
`else
                    if (pending_q == HALT_ADDR) begin
                        pc_d    = HALT_ADDR;
                        state_d = HALTED;
                    end else begin
                        // Low target bits are dropped rather than trapped in this build.
                        pc_d    = {pending_q[31:2], 2'b00};
                        state_d = RUN;
                    end
`endif
                end
                HALTED: begin
                    pc_d = HALT_ADDR;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            pending_q <= 32'h0;
            state_q   <= RUN;
        end else begin
            pc_q      <= pc_d;
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

`ifdef MIPS_PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_error_q <= 1'b0;
        end else begin
            addr_error_q <= addr_error_d;
        end
    end
    assign addr_error = addr_error_q;
`else
    assign addr_error = 1'b0;
`endif

    assign instr_address = pc_q;
    assign link_addr     = pc_q + LINK_OFFSET;
    assign in_delay_slot = (state_q == DELAY);
    assign active        = (state_q != HALTED);

endmodule
